obj_manager: RTL and testbench

- Parametrised successor to the single-screen game logic object handling.
- Owns NUM_OBJ object slots. Once per video frame it scans them sequentially, one slot per clock: scroll left by speed, advance the animation frame, detect collision with the player, score, and spawn new objects from the random word.
- Sits between the rng/vsync pulse logic and the sprite renderer; its packed slot bus replaces the fixed p_obj1..p_obj5 ports.

---
 rtl/obj_pkg.sv | 20 ++
 rtl/obj_slot_step.sv | 82 ++++++++
 rtl/obj_manager.sv | 170 +++++++++++++++++
 tb/tb_obj_manager.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared slot layout and controller state encoding for obj_manager.
package obj_pkg;

  localparam int OBJ_W     = 26;
  localparam int FRAME_MSB = 25;
  localparam int FRAME_LSB = 23;
  localparam int ID_MSB    = 22;
  localparam int ID_LSB    = 21;
  localparam int X_MSB     = 20;
  localparam int X_LSB     = 10;
  localparam int Y_MSB     = 9;
  localparam int Y_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/obj_slot_step.sv
// Combinational next value for one object slot: collision, scroll/exit, animation, spawn.
// OBJ_MANAGER_OBSTACLE_EN makes identity bit 21 an obstacle that costs SCORE_PENALTY.
module obj_slot_step
  import obj_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 1024,
  parameter int CHAR_WIDTH    = 20,
  parameter int CHAR_HEIGHT   = 20,
  parameter int OBJ_HEIGHT    = 20,
  parameter int Y_BASE        = 220,
  parameter int SCORE_PENALTY = 2
) (
  input  logic [OBJ_W-1:0] slot,
  input  logic [4:0]       idx,
  input  logic [31:0]      rnd,
  input  logic [3:0]       speed,
  input  logic [9:0]       p_vpos,
  input  logic             anim_zero,
  input  logic             spawn_done,
  output logic [OBJ_W-1:0] slot_nx,
  output logic signed [8:0] score_delta,
  output logic             spawned
);

`ifdef OBJ_MANAGER_OBSTACLE_EN
  localparam bit OBSTACLE_EN = 1'b1;
`else
  localparam bit OBSTACLE_EN = 1'b0;
`endif

  localparam logic [10:0] SW = 11'(SCREEN_WIDTH);
  localparam logic [10:0] CW = 11'(CHAR_WIDTH);
  localparam logic [10:0] CH = 11'(CHAR_HEIGHT);
  localparam logic [10:0] OH = 11'(OBJ_HEIGHT);
  localparam logic [9:0]  YB = 10'(Y_BASE);
  localparam logic signed [8:0] PEN = 9'(SCORE_PENALTY);

  logic        empty;
  logic [10:0] x;
  logic [10:0] y11;
  logic [10:0] pv11;
  logic [3:0]  nib;
  logic [7:0]  byt;
  logic        hit;
  logic        exit_left;

  assign empty = (slot == '0);
  assign x     = slot[X_MSB:X_LSB];
  assign y11   = {1'b0, slot[Y_MSB:Y_LSB]};
  assign pv11  = {1'b0, p_vpos};
  assign nib   = rnd[{idx[2:0], 2'b00} +: 4];
  assign byt   = rnd[{idx[1:0], 3'b000} +: 8];

  // An empty slot reads as x=0,y=0, so it must never count as a hit.
  assign hit = !empty && (x < CW) && (y11 < pv11 + CH) && (y11 + OH > pv11);
  assign exit_left = (speed != 4'd0) && (x <= {7'd0, speed});

  always_comb begin
    slot_nx     = slot;
    score_delta = '0;
    spawned     = 1'b0;
    if (empty) begin
      if (!spawn_done && nib == 4'd0) begin
        slot_nx                = '0;
        slot_nx[ID_LSB]        = rnd[idx];
        slot_nx[X_MSB:X_LSB]   = SW;
        slot_nx[Y_MSB:Y_LSB]   = YB + {2'b00, byt};
        spawned                = 1'b1;
      end
    end else if (hit) begin
      slot_nx     = '0;
      score_delta = (OBSTACLE_EN && slot[ID_LSB]) ? -PEN : 9'sd1;
    end else if (exit_left) begin
      slot_nx = '0;
    end else begin
      slot_nx[X_MSB:X_LSB] = x - {7'd0, speed};
      if (anim_zero)
        slot_nx[FRAME_MSB:FRAME_LSB] = slot[FRAME_MSB:FRAME_LSB] + 3'd1;
    end
  end

endmodule

// File: rtl/obj_manager.sv
// Object slot manager: one slot per clock scan per video frame, scoring and spawning.
// Build option OBJ_MANAGER_OBSTACLE_EN enables obstacle penalties (see obj_slot_step).
//
// state | meaning
// IDLE  | waiting for start, frame ticks ignored
// PLAY  | game running, waiting for a frame tick
// SCAN  | updating slot idx each clock, busy=1
module obj_manager
  import obj_pkg::*;
#(
  parameter int NUM_OBJ       = 8,
  parameter int SCREEN_WIDTH  = 1024,
  parameter int CHAR_WIDTH    = 20,
  parameter int CHAR_HEIGHT   = 20,
  parameter int OBJ_HEIGHT    = 20,
  parameter int Y_BASE        = 220,
  parameter int ANIM_DIV      = 8,
  parameter int SCORE_PENALTY = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     frame_tick,
  input  logic [3:0]               speed,
  input  logic [9:0]               p_vpos,
  input  logic [31:0]              random,
  output logic [OBJ_W*NUM_OBJ-1:0] objs,
  output logic [7:0]               score,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     tick_overrun
);

  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);

  state_t           state, state_nx;
  logic [OBJ_W-1:0] slots_q [NUM_OBJ];
  logic [IW-1:0]    idx;
  logic [AW-1:0]    anim_cnt;
  logic [31:0]      rnd_q;
  logic             spawn_done;

  logic clear_all, scan_begin, slot_we, scan_last, overrun_set;

  logic [OBJ_W-1:0]  step_slot;
  logic signed [8:0] step_delta;
  logic              step_spawned;
  logic signed [9:0] score_sum;
  logic [7:0]        score_nx;

  obj_slot_step #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .CHAR_WIDTH   (CHAR_WIDTH),
    .CHAR_HEIGHT  (CHAR_HEIGHT),
    .OBJ_HEIGHT   (OBJ_HEIGHT),
    .Y_BASE       (Y_BASE),
    .SCORE_PENALTY(SCORE_PENALTY)
  ) u_step (
    .slot       (slots_q[idx]),
    .idx        (5'(idx)),
    .rnd        (rnd_q),
    .speed      (speed),
    .p_vpos     (p_vpos),
    .anim_zero  (anim_cnt == '0),
    .spawn_done (spawn_done),
    .slot_nx    (step_slot),
    .score_delta(step_delta),
    .spawned    (step_spawned)
  );

  // Saturate at 255 on reward, floor at 0 on penalty.
  assign score_sum = $signed({2'b00, score}) + $signed({step_delta[8], step_delta});
  always_comb begin
    score_nx = score_sum[7:0];
    if (score_sum < 10'sd0)
      score_nx = 8'd0;
    else if (score_sum > 10'sd255)
      score_nx = 8'd255;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    clear_all   = 1'b0;
    scan_begin  = 1'b0;
    slot_we     = 1'b0;
    scan_last   = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = PLAY;
          clear_all = 1'b1;
        end
      end
      PLAY: begin
        if (start) begin
          clear_all = 1'b1;
        end else if (frame_tick) begin
          state_nx   = SCAN;
          scan_begin = 1'b1;
        end
      end
      SCAN: begin
        if (start) begin
          state_nx  = PLAY;
          clear_all = 1'b1;
        end else begin
          slot_we     = 1'b1;
          overrun_set = frame_tick;
          if (idx == LAST) begin
            scan_last = 1'b1;
            state_nx  = PLAY;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) slots_q[i] <= '0;
      score        <= '0;
      idx          <= '0;
      anim_cnt     <= '0;
      rnd_q        <= '0;
      spawn_done   <= 1'b0;
      tick_overrun <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      scan_done <= scan_last;
      if (clear_all) begin
        for (int i = 0; i < NUM_OBJ; i++) slots_q[i] <= '0;
        score        <= '0;
        idx          <= '0;
        anim_cnt     <= '0;
        spawn_done   <= 1'b0;
        tick_overrun <= 1'b0;
      end else begin
        if (scan_begin) begin
          idx        <= '0;
          rnd_q      <= random;
          anim_cnt   <= (ANIM_DIV > 1) ? anim_cnt + 1'b1 : '0;
          spawn_done <= 1'b0;
        end
        if (slot_we) begin
          slots_q[idx] <= step_slot;
          score        <= score_nx;
          idx          <= scan_last ? '0 : idx + 1'b1;
          if (step_spawned) spawn_done <= 1'b1;
        end
        if (overrun_set) tick_overrun <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_objs
    assign objs[OBJ_W*g +: OBJ_W] = slots_q[g];
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_obj_manager.sv
// Self-checking bench for obj_manager: frame-level reference model with a scoreboard,
// a table of scroll/spawn vectors, and hand sequences for overrun, abort and reset.
module tb_obj_manager;

  localparam int N  = 8;
  localparam int OW = 26;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          frame_tick = 1'b0;
  logic [3:0]    speed = 4'd0;
  logic [9:0]    p_vpos = 10'd0;
  logic [31:0]   random = 32'd0;
  logic [OW*N-1:0] objs;
  logic [7:0]    score;
  logic          busy, scan_done, tick_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  obj_manager #(.NUM_OBJ(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .frame_tick  (frame_tick),
    .speed       (speed),
    .p_vpos      (p_vpos),
    .random      (random),
    .objs        (objs),
    .score       (score),
    .busy        (busy),
    .scan_done   (scan_done),
    .tick_overrun(tick_overrun)
  );

  typedef struct {
    logic [OW*N-1:0] objs;
    logic [7:0]      score;
  } exp_t;

  typedef struct {
    int          n;
    logic [3:0]  sp;
    logic [9:0]  pv;
    logic [31:0] rn;
    logic [25:0] exp_slot0;
    logic [7:0]  exp_score;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [OW-1:0] m_slot [N];
  int          m_score;
  int          m_anim;
  vec_t        tbl [8];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [25:0] mk(int fr, int id, int x, int y);
    return {3'(fr), 2'(id), 11'(x), 10'(y)};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_slot[i] = '0;
    m_score = 0;
    m_anim  = 0;
    sb_q.delete();
  endfunction

  // Reference model of one complete scan, built from the frame-level rules.
  function automatic void model_frame(logic [3:0] sp, logic [9:0] pv, logic [31:0] rn);
    exp_t e;
    int x, y, fr, idv, s, p;
    bit spawned;
    s = int'(sp);
    p = int'(pv);
    spawned = 1'b0;
    m_anim = (m_anim + 1) % 8;
    for (int i = 0; i < N; i++) begin
      fr  = int'(m_slot[i][25:23]);
      idv = int'(m_slot[i][22:21]);
      x   = int'(m_slot[i][20:10]);
      y   = int'(m_slot[i][9:0]);
      if (m_slot[i] == '0) begin
        if (!spawned && ((rn >> (4 * (i % 8))) & 32'hF) == 32'd0) begin
          m_slot[i] = {3'd0, 1'b0, rn[i], 11'd1024,
                       10'(220 + int'((rn >> (8 * (i % 4))) & 32'hFF))};
          spawned = 1'b1;
        end
      end else if (x < 20 && y < p + 20 && y + 20 > p) begin
        m_slot[i] = '0;
`ifdef OBJ_MANAGER_OBSTACLE_EN
        if ((idv & 1) != 0) m_score = (m_score < 2) ? 0 : m_score - 2;
        else                m_score = (m_score == 255) ? 255 : m_score + 1;
`else
        m_score = (m_score == 255) ? 255 : m_score + 1;
`endif
      end else if (s != 0 && x <= s) begin
        m_slot[i] = '0;
      end else begin
        x = x - s;
        if (m_anim == 0) fr = (fr + 1) % 8;
        m_slot[i] = {3'(fr), 2'(idv), 11'(x), 10'(y)};
      end
    end
    for (int i = 0; i < N; i++) e.objs[OW*i +: OW] = m_slot[i];
    e.score = 8'(m_score);
    sb_q.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (reset_n && scan_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_scan_done: got scan_done=1 expected no pending frame");
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_objs", 256'(objs), 256'(mon_e.objs));
        chk("sb_score", 256'(score), 256'(mon_e.score));
      end
    end
  end

  task automatic do_frame(input logic [3:0] sp, input logic [9:0] pv, input logic [31:0] rn);
    bit got;
    @(negedge clock);
    speed = sp;
    p_vpos = pv;
    random = rn;
    frame_tick = 1'b1;
    model_frame(sp, pv, rn);
    @(negedge clock);
    frame_tick = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4 * N + 8 && !got; k++) begin
      @(negedge clock);
      if (scan_done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got no scan_done expected one within %0d cycles", 4 * N + 8);
    end
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    model_clear();
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt;

    tbl[0] = '{1,  4'd15, 10'd0, 32'h0000_0030, mk(0, 0, 1024, 268), 8'd0};
    tbl[1] = '{6,  4'd15, 10'd0, 32'hFFFF_FFFF, mk(0, 0,  934, 268), 8'd0};
    tbl[2] = '{1,  4'd15, 10'd0, 32'hFFFF_FFFF, mk(1, 0,  919, 268), 8'd0};
    tbl[3] = '{60, 4'd15, 10'd0, 32'hFFFF_FFFF, mk(0, 0,   19, 268), 8'd0};
    tbl[4] = '{1,  4'd14, 10'd0, 32'hFFFF_FFFF, mk(0, 0,    5, 268), 8'd0};
    tbl[5] = '{1,  4'd0,  10'd0, 32'hFFFF_FFFF, mk(0, 0,    5, 268), 8'd0};
    tbl[6] = '{1,  4'd3,  10'd0, 32'hFFFF_FFFF, mk(0, 0,    2, 268), 8'd0};
    tbl[7] = '{1,  4'd3,  10'd0, 32'hFFFF_FFFF, 26'd0,               8'd0};

    model_clear();
    repeat (3) @(negedge clock);
    chk("rst_objs", 256'(objs), 256'd0);
    chk("rst_score", 256'(score), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_scan_done", 256'(scan_done), 256'd0);
    chk("rst_overrun", 256'(tick_overrun), 256'd0);
    reset_n = 1'b1;

    // Frame ticks in IDLE are ignored.
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    chk("idle_busy", 256'(busy), 256'd0);
    chk("idle_overrun", 256'(tick_overrun), 256'd0);

    // Spawn, scroll, animation wrap, speed 0, exit left.
    do_start();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < tbl[r].n; k++) do_frame(tbl[r].sp, tbl[r].pv, tbl[r].rn);
      chk($sformatf("tbl%0d_slot0", r), 256'(objs[OW-1:0]), 256'(tbl[r].exp_slot0));
      chk($sformatf("tbl%0d_score", r), 256'(score), 256'(tbl[r].exp_score));
      if (r == 0) chk("tbl0_only_one_spawn", 256'(objs[OW*N-1:OW]), 256'd0);
    end

    // Collectable then identity-1 collision.
    do_start();
    do_frame(4'd15, 10'd220, 32'h0000_0000);
    do_frame(4'd15, 10'd220, 32'h0000_0002);
    chk("id1_spawn", 256'(objs[2*OW-1:OW]), 256'(mk(0, 1, 1024, 220)));
    for (int k = 0; k < 66; k++) do_frame(4'd15, 10'd220, 32'hFFFF_FFFF);
    do_frame(4'd15, 10'd220, 32'hFFFF_FFFF);
    chk("collect_score", 256'(score), 256'd1);
    do_frame(4'd15, 10'd220, 32'hFFFF_FFFF);
`ifdef OBJ_MANAGER_OBSTACLE_EN
    chk("obstacle_score", 256'(score), 256'd0);
`else
    chk("obstacle_score", 256'(score), 256'd2);
`endif

    // Second tick two cycles into a scan is dropped and flagged.
    @(negedge clock);
    speed = 4'd15;
    p_vpos = 10'd0;
    random = 32'hFFFF_FFFF;
    frame_tick = 1'b1;
    model_frame(4'd15, 10'd0, 32'hFFFF_FFFF);
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (scan_done) done_cnt++;
      frame_tick = (k == 2);
    end
    chk("busy_cycles", 256'(busy_cnt), 256'd8);
    chk("scan_done_pulses", 256'(done_cnt), 256'd1);
    chk("overrun_set", 256'(tick_overrun), 256'd1);
    do_frame(4'd15, 10'd0, 32'h0000_0000);
    chk("overrun_sticky", 256'(tick_overrun), 256'd1);

    // Start during a scan aborts and clears everything.
    @(negedge clock);
    random = 32'h0000_0000;
    frame_tick = 1'b1;
    model_frame(4'd15, 10'd0, 32'h0000_0000);
    @(negedge clock);
    frame_tick = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b1;
    model_clear();
    @(negedge clock);
    start = 1'b0;
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_objs", 256'(objs), 256'd0);
    chk("abort_score", 256'(score), 256'd0);
    chk("abort_overrun", 256'(tick_overrun), 256'd0);
    do_frame(4'd15, 10'd0, 32'h0000_0000);

    // Long run of collectables to reach and hold saturation.
    do_start();
    for (int k = 0; k < 2400; k++) do_frame(4'd15, 10'd220, 32'h0000_0000);
    chk("score_saturated", 256'(score), 256'd255);

    // Asynchronous reset in the middle of a scan.
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_objs", 256'(objs), 256'd0);
    chk("arst_score", 256'(score), 256'd0);
    chk("arst_busy", 256'(busy), 256'd0);
    chk("arst_overrun", 256'(tick_overrun), 256'd0);
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    chk("arst_idle_busy", 256'(busy), 256'd0);
    do_start();
    do_frame(4'd7, 10'd300, 32'h1234_5600);
    do_frame(4'd7, 10'd300, 32'h0000_0F00);

    repeat (2) @(negedge clock);
    chk("sb_drained", 256'(sb_q.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
